// File: rtl/struct_logic_pkg.sv
// Shared types for the struct-port bitwise logic pipeline: operand struct,
// opcode enum and the widest supported operand width.
package struct_logic_pkg;

  localparam int PKG_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_XOR  = 2'b00,
    OP_AND  = 2'b01,
    OP_OR   = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  typedef struct packed {
    logic [PKG_MAX_W-1:0] a_in;
    logic [PKG_MAX_W-1:0] b_in;
    op_e                  op;
  } struct_port_t;

endpackage

// File: rtl/struct_logic_op_unit.sv
// Combinational WIDTH-bit bitwise evaluator: XOR, AND, OR or XNOR of a and b.
module struct_logic_op_unit
  import struct_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/struct_logic_pipe.sv
// Two-stage valid/ready bitwise logic pipeline with a wrapping delivered-result
// counter. Define STRUCT_LOGIC_PARITY_EN to add the registered y_parity output.
module struct_logic_pipe
  import struct_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  struct_port_t       i_port,
  input  logic               i_valid,
  output logic               i_ready,
  output logic [WIDTH-1:0]   y_out,
  output logic               o_valid,
  input  logic               o_ready,
`ifdef STRUCT_LOGIC_PARITY_EN
  output logic               y_parity,
`endif
  output logic [CNT_W-1:0]   txn_count
);

  if (WIDTH < 1 || WIDTH > PKG_MAX_W) begin : g_bad_width
    $error("struct_logic_pipe: WIDTH must be within 1..PKG_MAX_W");
  end

  // Handshake rule: a transfer happens on a rising edge where valid && ready;
  // valid may not depend on ready, and i_ready here is combinational from o_ready.
  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic             s2_p_q, s2_p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_can_accept;
  logic             in_hs;
  logic             out_hs;
  logic [WIDTH-1:0] op_y;

  // Operand bits above WIDTH are dropped on purpose.
  logic unused_port_bits;
  assign unused_port_bits = ^{i_port.a_in, i_port.b_in};

  assign s2_can_accept = !s2_v_q || o_ready;
  assign i_ready       = !s1_v_q || s2_can_accept;
  assign in_hs         = i_valid && i_ready;
  assign out_hs        = s2_v_q && o_ready;

  struct_logic_op_unit #(
    .WIDTH (WIDTH)
  ) u_op_unit (
    .a  (s1_a_q),
    .b  (s1_b_q),
    .op (s1_op_q),
    .y  (op_y)
  );

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_op_d = s1_op_q;
    s2_v_d  = s2_v_q;
    s2_y_d  = s2_y_q;
    s2_p_d  = s2_p_q;
    cnt_d   = cnt_q;

    // S2 advances whenever it is empty or being drained this cycle.
    if (s2_can_accept) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_y_d = op_y;
        s2_p_d = ^op_y;
      end
    end

    if (in_hs) begin
      s1_v_d  = 1'b1;
      s1_a_d  = i_port.a_in[WIDTH-1:0];
      s1_b_d  = i_port.b_in[WIDTH-1:0];
      s1_op_d = i_port.op;
    end else if (s1_v_q && s2_can_accept) begin
      s1_v_d = 1'b0;
    end

    if (out_hs) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_op_q <= OP_XOR;
      s2_v_q  <= 1'b0;
      s2_y_q  <= '0;
      s2_p_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_op_q <= s1_op_d;
      s2_v_q  <= s2_v_d;
      s2_y_q  <= s2_y_d;
      s2_p_q  <= s2_p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y_out     = s2_y_q;
  assign o_valid   = s2_v_q;
  assign txn_count = cnt_q;

`ifdef STRUCT_LOGIC_PARITY_EN
  assign y_parity = s2_p_q;
`else
  logic unused_parity;
  assign unused_parity = s2_p_q;
`endif

endmodule
